// File: rtl/pipelined_addsub.sv
// pipelined_addsub: valid/ready pipelined two's-complement adder/subtractor.
// The carry chain is cut into STAGES registered CHUNK-bit segments with skewed operands.
module pipelined_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg,
    output logic [TAG_W-1:0] out_tag
);
    localparam int CHUNK = WIDTH / STAGES;

    logic [STAGES-1:0] v_q, v_d, v_p;
    logic [STAGES-1:0] c_q, c_d, c_p;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  a_p [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  b_p [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic [WIDTH-1:0]  s_p [STAGES];
    logic [TAG_W-1:0]  t_q [STAGES];
    logic [TAG_W-1:0]  t_d [STAGES];
    logic [TAG_W-1:0]  t_p [STAGES];
    logic              ovf_q, ovf_d, zero_q, zero_d, neg_q, neg_d;
    logic              adv;
    logic [CHUNK:0]    r;
    logic [WIDTH-1:0]  sn;

    always_comb begin
        adv      = ~v_q[STAGES-1] | out_ready;
        in_ready = adv & ~flush & rst_n;
        v_p[0]   = in_valid & in_ready;
        a_p[0]   = in_a;
        b_p[0]   = in_sub ? ~in_b : in_b;
        c_p[0]   = in_sub;
        s_p[0]   = '0;
        t_p[0]   = in_tag;
        for (int k = 1; k < STAGES; k++) begin
            v_p[k] = v_q[k-1];
            a_p[k] = a_q[k-1];
            b_p[k] = b_q[k-1];
            c_p[k] = c_q[k-1];
            s_p[k] = s_q[k-1];
            t_p[k] = t_q[k-1];
        end
        r  = '0;
        sn = '0;
        // Each stage resolves only its own chunk, so sn ends holding the final-stage sum.
        for (int k = 0; k < STAGES; k++) begin
            r  = {1'b0, a_p[k][k*CHUNK +: CHUNK]} + {1'b0, b_p[k][k*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, c_p[k]};
            sn = s_p[k];
            sn[k*CHUNK +: CHUNK] = r[CHUNK-1:0];
            s_d[k] = adv ? sn : s_q[k];
            c_d[k] = adv ? r[CHUNK] : c_q[k];
            a_d[k] = adv ? a_p[k] : a_q[k];
            b_d[k] = adv ? b_p[k] : b_q[k];
            t_d[k] = adv ? t_p[k] : t_q[k];
        end
        v_d    = flush ? '0 : adv ? v_p : v_q;
        ovf_d  = adv ? ((a_p[STAGES-1][WIDTH-1] == b_p[STAGES-1][WIDTH-1]) & (sn[WIDTH-1] != a_p[STAGES-1][WIDTH-1])) : ovf_q;
        zero_d = adv ? ~|sn : zero_q;
        neg_d  = adv ? sn[WIDTH-1] : neg_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= '0;
            c_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                t_q[k] <= '0;
            end
        end else begin
            v_q    <= v_d;
            c_q    <= c_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
            neg_q  <= neg_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
                t_q[k] <= t_d[k];
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign out_sum   = s_q[STAGES-1];
    assign out_carry = c_q[STAGES-1];
    assign out_tag   = t_q[STAGES-1];
    assign out_ovf   = ovf_q;
    assign out_zero  = zero_q;
    assign out_neg   = neg_q;
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: directed vector bench for pipelined_addsub (32/4 and 8/1 configs).
module tb_pipelined_addsub;
    logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid = 0, in_ready, in_sub = 0, out_valid, out_ready = 1;
    logic [31:0] in_a = 0, in_b = 0, out_sum;
    logic [4:0]  in_tag = 0, out_tag;
    logic        out_carry, out_ovf, out_zero, out_neg;

    logic        in_valid8 = 0, in_ready8, in_sub8 = 0, out_valid8, out_ready8 = 1;
    logic [7:0]  in_a8 = 0, in_b8 = 0, out_sum8;
    logic [4:0]  in_tag8 = 0, out_tag8;
    logic        out_carry8, out_ovf8, out_zero8, out_neg8;

    pipelined_addsub #(.WIDTH(32), .STAGES(4), .TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_carry(out_carry), .out_ovf(out_ovf),
        .out_zero(out_zero), .out_neg(out_neg), .out_tag(out_tag));

    pipelined_addsub #(.WIDTH(8), .STAGES(1), .TAG_W(5)) dut8 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_a(in_a8), .in_b(in_b8), .in_sub(in_sub8), .in_tag(in_tag8), .out_valid(out_valid8),
        .out_ready(out_ready8), .out_sum(out_sum8), .out_carry(out_carry8), .out_ovf(out_ovf8),
        .out_zero(out_zero8), .out_neg(out_neg8), .out_tag(out_tag8));

    typedef struct {
        logic        sub;
        logic [31:0] a, b, sum;
        logic        c, o, z, n;
    } vec_t;

    vec_t vt [9];
    int   tests = 0, fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input vec_t v, input int id);
        int lat;
        in_valid  = 1;
        in_a      = v.a;
        in_b      = v.b;
        in_sub    = v.sub;
        in_tag    = 5'(id);
        out_ready = 1;
        tick;
        in_valid = 0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick;
            lat++;
        end
        chk($sformatf("latency[%0d]", id), 32'(lat), 32'd4);
        chk($sformatf("sum[%0d]", id), out_sum, v.sum);
        chk($sformatf("flags_cozn[%0d]", id), {28'd0, out_carry, out_ovf, out_zero, out_neg}, {28'd0, v.c, v.o, v.z, v.n});
        chk($sformatf("tag[%0d]", id), {27'd0, out_tag}, 32'(id));
        tick;
    endtask

    logic [31:0] exp_s [10];
    logic [31:0] sa, sb, held_sum;
    logic [4:0]  held_tag;
    logic [3:0]  pat;
    logic        prev_stall, seen;
    int          sent, got, cyc, lat;

    initial begin
        vt[0] = '{0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 0, 1, 0};
        vt[1] = '{0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 1, 0, 1};
        vt[2] = '{1, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 0, 0, 0, 1};
        vt[3] = '{1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1, 1, 0, 0};
        vt[4] = '{1, 32'h00000007, 32'h00000007, 32'h00000000, 1, 0, 1, 0};
        vt[5] = '{0, 32'h12345678, 32'h0F0F0F0F, 32'h21436587, 0, 0, 0, 0};
        vt[6] = '{0, 32'h80000000, 32'h80000000, 32'h00000000, 1, 1, 1, 0};
        vt[7] = '{1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 0, 0, 0, 1};
        vt[8] = '{0, 32'h00FFFFFF, 32'h00000001, 32'h01000000, 0, 0, 0, 0};

        #1;
        chk("reset_out_valid", {31'd0, out_valid}, 0);
        chk("reset_in_ready", {31'd0, in_ready}, 0);
        chk("reset_out_sum", out_sum, 0);
        #21 rst_n = 1;
        tick;

        for (int i = 0; i < 9; i++) run_op(vt[i], i);

        // Streaming with out_ready pattern 1,0,0,1
        pat = 4'b1001;
        sent = 0; got = 0; cyc = 0; prev_stall = 0;
        held_sum = 0; held_tag = 0;
        for (int i = 0; i < 10; i++) begin
            sa = 32'(i) * 32'h01010101;
            sb = 32'hFFFFFFF0 + 32'(i);
            exp_s[i] = i[0] ? sa - sb : sa + sb;
        end
        while (got < 10 && cyc < 200) begin
            out_ready = pat[cyc % 4];
            in_valid  = sent < 10;
            in_a      = 32'(sent) * 32'h01010101;
            in_b      = 32'hFFFFFFF0 + 32'(sent);
            in_sub    = sent[0];
            in_tag    = 5'(sent);
            #1;
            chk("stream_in_ready", {31'd0, in_ready}, {31'd0, !(out_valid && !out_ready)});
            if (prev_stall) chk("stall_stable", {out_sum[26:0], out_tag}, {held_sum[26:0], held_tag});
            if (out_valid && out_ready) begin
                chk("stream_tag", {27'd0, out_tag}, 32'(got));
                chk("stream_sum", out_sum, exp_s[got]);
                got++;
            end
            prev_stall = out_valid && !out_ready;
            held_sum   = out_sum;
            held_tag   = out_tag;
            if (in_valid && in_ready) sent++;
            tick;
            cyc++;
        end
        in_valid = 0;
        out_ready = 1;
        chk("stream_count", 32'(got), 10);
        seen = 0;
        repeat (6) begin
            seen |= out_valid;
            tick;
        end
        chk("stream_no_dup", {31'd0, seen}, 0);

        // Flush kills 3 in-flight beats plus the one presented during flush
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_a = 32'(i); in_b = 1; in_sub = 0; in_tag = 5'(20 + i);
            tick;
        end
        flush = 1;
        in_a = 99;
        #1;
        chk("flush_in_ready", {31'd0, in_ready}, 0);
        tick;
        flush = 0;
        in_valid = 0;
        seen = 0;
        repeat (10) begin
            seen |= out_valid;
            tick;
        end
        chk("flush_no_result", {31'd0, seen}, 0);
        run_op(vt[5], 11);

        // Flush drops a result held at a stalled output
        out_ready = 0;
        in_valid = 1; in_a = 10; in_b = 20; in_sub = 0; in_tag = 7;
        tick;
        in_valid = 0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick;
            lat++;
        end
        tick;
        tick;
        chk("held_valid", {31'd0, out_valid}, 1);
        chk("held_sum", out_sum, 30);
        flush = 1;
        tick;
        flush = 0;
        chk("flush_drop_held", {31'd0, out_valid}, 0);
        out_ready = 1;
        tick;

        // Asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) begin
            in_valid = 1; in_a = 32'(i); in_b = 1; in_sub = 0; in_tag = 5'(i);
            tick;
        end
        in_valid = 0;
        chk("pre_reset_valid", {31'd0, out_valid}, 1);
        #2 rst_n = 0;
        #1;
        chk("async_reset_valid", {31'd0, out_valid}, 0);
        chk("async_reset_sum", out_sum, 0);
        chk("async_reset_in_ready", {31'd0, in_ready}, 0);
        tick;
        tick;
        rst_n = 1;
        seen = 0;
        repeat (8) begin
            seen |= out_valid;
            tick;
        end
        chk("no_stale_after_reset", {31'd0, seen}, 0);
        run_op(vt[0], 12);

        // Single-stage 8-bit configuration
        in_valid8 = 1; in_a8 = 8'hFF; in_b8 = 8'h01; in_sub8 = 0; in_tag8 = 3; out_ready8 = 1;
        tick;
        in_valid8 = 0;
        lat = 1;
        while (!out_valid8 && lat < 20) begin
            tick;
            lat++;
        end
        chk("w8_latency", 32'(lat), 1);
        chk("w8_sum", {24'd0, out_sum8}, 0);
        chk("w8_flags_cozn", {28'd0, out_carry8, out_ovf8, out_zero8, out_neg8}, 32'b1010);
        chk("w8_tag", {27'd0, out_tag8}, 3);
        tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
Parametrised, pipelined two's-complement adder/subtractor for the MIPS execute path. It splits the WIDTH-bit carry chain into STAGES registered segments so wide adds close timing. It uses a valid/ready handshake, passes a tag through for destination tracking, and produces carry, overflow, zero and negative flags. It supports a synchronous flush for pipeline squash.

Parameters:
WIDTH, 32, operand/result width in bits; must be >= 2.
STAGES, 4, pipeline segments; must divide WIDTH exactly. CHUNK = WIDTH/STAGES.
TAG_W, 5, width of the pass-through tag (destination register id).

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous squash of all in-flight operations.
in_valid  input  1  operand beat valid.
in_ready  output  1  block can accept a beat this cycle.
in_a  input  WIDTH  operand A.
in_b  input  WIDTH  operand B.
in_sub  input  1  0 = A+B, 1 = A-B.
in_tag  input  TAG_W  opaque tag returned with the result.
out_valid  output  1  result beat valid.
out_ready  input  1  consumer accepts the result.
out_sum  output  WIDTH  result.
out_carry  output  1  carry out of the MSB. For SUB, 1 means no borrow.
out_ovf  output  1  signed overflow.
out_zero  output  1  out_sum == 0.
out_neg  output  1  out_sum[WIDTH-1].
out_tag  output  TAG_W  tag of this result.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits, out_valid, out_sum, the flags and out_tag go to 0 immediately. In-flight operations are discarded. in_ready = 0 while rst_n is low.
- Advance condition: adv = ~out_valid | out_ready. This is a single global enable; all stages shift together when adv = 1.
- in_ready = adv & ~flush & rst_n. A beat is accepted when in_valid & in_ready.
- Operand conditioning at acceptance:
  - b_eff = in_sub ? ~in_b : in_b.
  - cin = in_sub.
- Stage k (0..STAGES-1) computes bits [k*CHUNK +: CHUNK] from the registered carry of stage k-1 (cin for stage 0).
  - Unprocessed upper operand bits are skewed forward in registers.
  - Completed lower sum bits are carried forward in registers.
- No combinational carry path spans more than CHUNK bits.
- Latency: exactly STAGES cycles from acceptance to out_valid, when adv stays 1.
- Throughput: 1 result per cycle while out_ready = 1.
- Stall (out_valid & ~out_ready): every stage register, including outputs, holds. out_* stay stable until accepted.
- Bubbles are not collapsed; empty stages shift like full ones.
- Flags, all computed in the final stage:
  - out_carry = carry out of bit WIDTH-1.
  - out_ovf = (a[MSB] == b_eff[MSB]) & (sum[MSB] != a[MSB]).
  - out_zero = ~|sum.
  - out_neg = sum[MSB].
- Flush: on a rising edge with flush = 1, all stage valid bits and out_valid clear. Data registers may keep stale values. A beat presented in the same cycle is not accepted (in_ready = 0). Flush overrides a simultaneous stall or output handshake; a result held at the output is dropped.
- Ordering: results emerge in acceptance order. No loss, no duplication.
- Wrap-around: the sum is modulo 2^WIDTH. Overflow is reported only through the flags.
- STAGES = 1 degenerates to a single registered adder with latency 1.

Test Plan:
1. W=32, S=4, ADD 0xFFFFFFFF + 0x00000001 -> 4 cycles later: sum 0x00000000, carry 1, zero 1, ovf 0, neg 0.
2. ADD 0x7FFFFFFF + 0x00000001 -> sum 0x80000000, ovf 1, neg 1, carry 0.
3. SUB 5 - 7 -> sum 0xFFFFFFFE, carry 0, neg 1. SUB 0x80000000 - 1 -> sum 0x7FFFFFFF, ovf 1, carry 1.
4. Back-to-back beats with tags 0..9, out_ready toggling 1,0,0,1,... -> 10 results in tag order with correct sums; out_* stable during stalls; in_ready low exactly when out_valid & ~out_ready.
5. Accept 3 beats, assert flush one cycle while in_valid = 1 -> no result ever emerges for those 4 beats; in_ready = 0 in the flush cycle; next beat gives out_valid after exactly 4 cycles.
6. Deassert rst_n mid-stream, between clock edges -> out_valid drops to 0 before the next edge; after release, the first accepted beat is correct and nothing stale appears. Repeat case 1 with W=8, S=1 -> latency 1, sum 0x00, carry 1.
